mux_sel_arbiter: RTL and testbench

Round-robin arbiter that sits directly upstream of the 4:1 channel mux and drives its select pair `{s1,s0}`. Four sources raise requests. The block grants one source at a time with one-cycle latency and a bounded hold time. It presents the winning index on `s1,s0` together with a `valid` qualifier and one-hot grants back to the sources.

---
 rtl/mux_sel_arbiter.sv | 103 ++++++++++
 tb/tb_mux_sel_arbiter.sv | 129 ++++++++++++
 2 files changed

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter driving the 4:1 channel mux select {s1,s0}.
// One-cycle grant latency, zero-bubble handover and a bounded hold time under contention.
module mux_sel_arbiter #(
  parameter int HOLD_MAX = 4,
  parameter int CNT_W    = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic r0,
  input  logic r1,
  input  logic r2,
  input  logic r3,
  output logic s1,
  output logic s0,
  output logic valid,
  output logic g0,
  output logic g1,
  output logic g2,
  output logic g3
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state;
  logic [3:0]       req;
  logic [3:0]       gnt;
  logic [3:0]       others;
  logic [1:0]       cur;
  logic [1:0]       cur_p1;
  logic [1:0]       ptr;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       pick_idle;
  logic [2:0]       pick_rot;
  logic             hold_done;

  // Returns {found, index}: first requester at or after start, wrapping mod 4.
  function automatic logic [2:0] rr_pick(input logic [3:0] rq, input logic [1:0] start);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      idx = start + 2'(i);
      if (rq[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign req       = {r3, r2, r1, r0};
  assign cur_p1    = cur + 2'd1;
  assign others    = req & ~(4'b0001 << cur);
  assign hold_done = (cnt == CNT_W'(HOLD_MAX));
  assign pick_idle = rr_pick(req, ptr);
  // Searching from cur+1 leaves cur at lowest priority, so rotation never re-picks it.
  assign pick_rot  = rr_pick(others, cur_p1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cur   <= 2'd0;
      ptr   <= 2'd0;
      cnt   <= '0;
      valid <= 1'b0;
      gnt   <= 4'b0000;
    end else begin
      case (state)
        IDLE: begin
          if (pick_idle[2]) begin
            cur   <= pick_idle[1:0];
            gnt   <= 4'b0001 << pick_idle[1:0];
            valid <= 1'b1;
            cnt   <= CNT_W'(1);
            state <= GRANT;
          end
        end
        GRANT: begin
          if (!req[cur] || (hold_done && |others)) begin
            ptr <= cur_p1;
            if (pick_rot[2]) begin
              cur <= pick_rot[1:0];
              gnt <= 4'b0001 << pick_rot[1:0];
              cnt <= CNT_W'(1);
            end else begin
              // cur is kept so the mux select holds its last value while idle.
              valid <= 1'b0;
              gnt   <= 4'b0000;
              cnt   <= '0;
              state <= IDLE;
            end
          end else if (hold_done) begin
            cnt <= CNT_W'(1);
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign {s1, s0}           = cur;
  assign {g3, g2, g1, g0}   = gnt;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Directed bench for mux_sel_arbiter: outputs sampled on the falling edge, inputs changed there too.
module tb_mux_sel_arbiter;

  logic clk, reset;
  logic r0, r1, r2, r3;
  logic s1, s0, valid, g0, g1, g2, g3;

  int errors = 0;
  int checks = 0;

  mux_sel_arbiter #(.HOLD_MAX(4), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .r0(r0), .r1(r1), .r2(r2), .r3(r3),
    .s1(s1), .s0(s0), .valid(valid),
    .g0(g0), .g1(g1), .g2(g2), .g3(g3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compares {valid, g3..g0, s1, s0} against the hand-derived expectation.
  task automatic chk(input string tag, input logic exp_v, input logic [3:0] exp_g, input logic [1:0] exp_s);
    logic [6:0] obs, exp;
    obs = {valid, g3, g2, g1, g0, s1, s0};
    exp = {exp_v, exp_g, exp_s};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed v/g/s=%b/%b/%b expected %b/%b/%b",
             tag, obs[6], obs[5:2], obs[1:0], exp[6], exp[5:2], exp[1:0]);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_req(input logic [3:0] r);
    {r3, r2, r1, r0} = r;
  endtask

  // Asynchronous reset pulse away from the clock edge, checked before the next edge.
  task automatic pulse_reset(input string tag);
    #2 reset = 1'b0;
    #1 chk(tag, 1'b0, 4'b0000, 2'b00);
    tick();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    set_req(4'b0000);

    // Reset then single request on source 2
    repeat (3) tick();
    chk("reset_state", 1'b0, 4'b0000, 2'b00);
    reset = 1'b1;
    tick();
    chk("idle_no_req", 1'b0, 4'b0000, 2'b00);
    set_req(4'b0100);
    tick();
    chk("single_r2_grant", 1'b1, 4'b0100, 2'b10);
    set_req(4'b0000);
    tick();
    chk("r2_release_sel_holds", 1'b0, 4'b0000, 2'b10);
    tick();
    chk("idle_stays", 1'b0, 4'b0000, 2'b10);

    // Full contention: 0,1,2,3,0 each for exactly 4 cycles
    pulse_reset("reset_before_contention");
    set_req(4'b1111);
    for (int k = 0; k < 20; k++) begin
      logic [1:0] idx;
      tick();
      idx = 2'((k / 4) % 4);
      chk($sformatf("contention_cyc%0d", k), 1'b1, 4'b0001 << idx, idx);
    end

    // Early release of source 1 hands over to 3 with no bubble
    set_req(4'b0000);
    pulse_reset("reset_before_skip");
    set_req(4'b1010);
    tick();
    chk("skip_grant1_a", 1'b1, 4'b0010, 2'b01);
    tick();
    chk("skip_grant1_b", 1'b1, 4'b0010, 2'b01);
    set_req(4'b1000);
    tick();
    chk("skip_move_to3", 1'b1, 4'b1000, 2'b11);
    set_req(4'b0000);
    tick();
    chk("skip_idle", 1'b0, 4'b0000, 2'b11);

    // Lone holder: ptr is 0, grant never drops while counter wraps
    set_req(4'b0001);
    for (int k = 0; k < 20; k++) begin
      tick();
      chk($sformatf("lone_r0_cyc%0d", k), 1'b1, 4'b0001, 2'b00);
    end
    set_req(4'b0000);
    tick();
    chk("lone_release", 1'b0, 4'b0000, 2'b00);

    // ptr is now 1: r3 wins, then release coincides with r0/r2 rising
    set_req(4'b1000);
    tick();
    chk("cur3_grant", 1'b1, 4'b1000, 2'b11);
    set_req(4'b0101);
    tick();
    chk("simul_release_r0_wins", 1'b1, 4'b0001, 2'b00);

    // Source 0 releases, ptr=1 so r2 wins; then async reset mid-grant
    set_req(4'b0100);
    tick();
    chk("grant2_before_reset", 1'b1, 4'b0100, 2'b10);
    #2 reset = 1'b0;
    #1 chk("async_reset_midgrant", 1'b0, 4'b0000, 2'b00);
    set_req(4'b1010);
    tick();
    chk("held_in_reset", 1'b0, 4'b0000, 2'b00);
    reset = 1'b1;
    tick();
    chk("post_reset_r1_first", 1'b1, 4'b0010, 2'b01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
